// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: a 16-word sliding window that streams W[t] and K[t]
// for rounds 0..63 to the round function under a valid/ready handshake.
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic         w_ready,
  output logic         w_valid,
  output logic [31:0]  w_out,
  output logic [31:0]  k_out,
  output logic [5:0]   round_idx,
  output logic         busy,
  output logic         done
);
  // state | meaning
  // IDLE  | waiting for start; window keeps its last contents
  // RUN   | presenting W/K for round_idx; advances on each handshake
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t      state, state_next;
  logic [31:0] win [16];
  logic [31:0] w_new;
  logic        load, fire, last;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  always_comb begin
    state_next = state;
    load       = 1'b0;
    fire       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (w_ready) begin
          fire = 1'b1;
          if (round_idx == 6'd63) begin
            last       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // win[14]=W[t-2], win[9]=W[t-7], win[1]=W[t-15], win[0]=W[t-16]
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      round_idx <= '0;
      done      <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        for (int i = 0; i < 16; i++) win[i] <= block_in[32*(15-i) +: 32];
        round_idx <= '0;
      end else if (fire) begin
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15]   <= w_new;
        round_idx <= round_idx + 6'd1;
      end
    end
  end

  assign w_valid = (state == RUN);
  assign busy    = (state == RUN);
  assign w_out   = win[0];
  assign k_out   = K_ROM[round_idx];

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: "abc" block, stalls, ignored starts,
// back-to-back blocks and reset mid-stream, checked against a textbook schedule model.
module tb_sha256_msg_schedule;
  logic         clk, rst_n, start, w_ready;
  logic [511:0] block_in;
  logic         w_valid, busy, done;
  logic [31:0]  w_out, k_out;
  logic [5:0]   round_idx;

  int n_pass   = 0;
  int n_checks = 0;

  logic [31:0]  exp_w [64];
  logic [31:0]  obs_w [64];
  logic [31:0]  obs_k [64];
  logic [31:0]  ref_w [64];
  logic [31:0]  ref_k [64];
  logic [511:0] abc, blk_b;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_msg_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .block_in  (block_in),
    .w_ready   (w_ready),
    .w_valid   (w_valid),
    .w_out     (w_out),
    .k_out     (k_out),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) exp_w[i] = blk[511-32*i -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = ssig1(exp_w[t-2]) + exp_w[t-7] + ssig0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Entered at the negedge where round 0 should be showing; returns at the
  // negedge of the done cycle, or at round abort_at without further action.
  task automatic stream(input logic [511:0] blk, input int stall_at, input int stall_len,
                        input int inject_at, input logic hold_start, input int abort_at);
    int t, cyc, stalls;
    t = 0; cyc = 1; stalls = 0;
    build_model(blk);
    while (t < 64 && cyc < 200) begin
      if (t == abort_at) return;
      check("w_valid", 64'(w_valid), 64'd1);
      check("busy", 64'(busy), 64'd1);
      check("done_low", 64'(done), 64'd0);
      check("round_idx", 64'(round_idx), 64'(t));
      check("w_out", 64'(w_out), 64'(exp_w[t]));
      check("k_out", 64'(k_out), 64'(KT[t]));
      obs_w[t] = w_out;
      obs_k[t] = k_out;
      start    = hold_start;
      block_in = blk;
      if (t == inject_at) begin
        start    = 1'b1;
        block_in = ~blk;
      end
      if (t == stall_at && stalls < stall_len) begin
        w_ready = 1'b0;
        stalls++;
      end else begin
        w_ready = 1'b1;
        t++;
      end
      @(negedge clk);
      cyc++;
    end
    check("rounds", 64'(t), 64'd64);
    check("done_pulse", 64'(done), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("done_valid", 64'(w_valid), 64'd0);
    check("done_cycle", 64'(cyc), 64'(65 + stall_len));
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    abc = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 16; i++) blk_b[511-32*i -: 32] = 32'h9e3779b9 * (i + 1);

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start    = 1'($urandom_range(0, 1));
      w_ready  = 1'($urandom_range(0, 1));
      block_in = {16{$urandom()}};
      @(negedge clk);
    end
    check("rst_valid", 64'(w_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_round", 64'(round_idx), 64'd0);
    check("rst_k", 64'(k_out), 64'h428a2f98);
    check("rst_w", 64'(w_out), 64'd0);
    start = 1'b0; w_ready = 1'b0; block_in = '0;
    rst_n = 1'b1;
    idle_check("post_rst");

    // "abc" block, ready tied high
    start = 1'b1; block_in = abc;
    @(negedge clk);
    start = 1'b0;
    stream(abc, -1, 0, -1, 1'b0, -1);
    check("abc_w0", 64'(obs_w[0]), 64'h61626380);
    check("abc_k0", 64'(obs_k[0]), 64'h428a2f98);
    check("abc_w15", 64'(obs_w[15]), 64'h00000018);
    check("abc_w16", 64'(obs_w[16]), 64'h61626380);
    check("abc_w17", 64'(obs_w[17]), 64'h000f0000);
    check("abc_k63", 64'(obs_k[63]), 64'hc67178f2);
    for (int i = 0; i < 64; i++) begin
      ref_w[i] = obs_w[i];
      ref_k[i] = obs_k[i];
    end
    idle_check("abc_after");

    // Stall 3 cycles at round 20
    start = 1'b1; block_in = abc;
    @(negedge clk);
    start = 1'b0;
    stream(abc, 20, 3, -1, 1'b0, -1);
    for (int i = 0; i < 64; i++) begin
      check("stall_w_same", 64'(obs_w[i]), 64'(ref_w[i]));
      check("stall_k_same", 64'(obs_k[i]), 64'(ref_k[i]));
    end
    idle_check("stall_after");

    // start with a different block at round 10 is ignored
    start = 1'b1; block_in = abc;
    @(negedge clk);
    start = 1'b0;
    stream(abc, -1, 0, 10, 1'b0, -1);
    idle_check("inject_after");

    // Back-to-back with start held high throughout
    start = 1'b1; block_in = blk_b;
    @(negedge clk);
    stream(blk_b, -1, 0, -1, 1'b1, -1);
    block_in = abc;
    @(negedge clk);
    stream(abc, -1, 0, -1, 1'b1, -1);
    start = 1'b0;
    idle_check("b2b_after");

    // Reset pulse at round 30, then a clean replay
    start = 1'b1; block_in = abc;
    @(negedge clk);
    start = 1'b0;
    stream(abc, -1, 0, -1, 1'b0, 30);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(w_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_round", 64'(round_idx), 64'd0);
    check("midrst_k", 64'(k_out), 64'h428a2f98);
    check("midrst_w", 64'(w_out), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle_check("midrst_idle");
    start = 1'b1; block_in = abc;
    @(negedge clk);
    start = 1'b0;
    stream(abc, -1, 0, -1, 1'b0, -1);
    idle_check("replay_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

SHA-256 message-schedule and round-constant generator. Latches one 512-bit message block, then streams the 64 round inputs Wi/Ki, one round per accepted handshake, to the round-compression logic. That logic consumes them as in_Wi/in_Ki, alongside the A..H working registers held by the round controller. The block is the stage directly upstream of the combinational round function.

## Interface
- No parameters; word width 32, window depth 16, round count 64 are fixed by SHA-256.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  load request; sampled only in IDLE
- block_in  in  512  message block; word 0 in [511:480], word 15 in [31:0], big-endian words
- w_ready  in  1  consumer accepts current round this cycle
- w_valid  out  1  w_out/k_out/round_idx valid
- w_out  out  32  schedule word W[round_idx]
- k_out  out  32  round constant K[round_idx]
- round_idx  out  6  current round 0..63
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after round 63 accepted

## Operation
- States: IDLE, RUN.
  - IDLE + start=1 → RUN. Load window win[0..15] ← block_in words 0..15. round_idx ← 0.
  - RUN, handshake (w_valid & w_ready):
    - Shift window down: win[i] ← win[i+1] for i=0..14.
    - win[15] ← σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32.
    - round_idx ← round_idx+1.
  - RUN, handshake with round_idx=63 → IDLE; done=1 next cycle.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x); σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Additions: plain 32-bit wrap, carries out discarded.
- Outputs:
  - w_out = win[0] (registered window, no combinational path from block_in).
  - k_out = 64-entry constant ROM indexed by round_idx (K[0]=0x428a2f98 … K[63]=0xc67178f2).
  - w_valid = busy = (state==RUN).
- Stall: w_ready=0 in RUN holds window, round_idx and all outputs stable.
- start while RUN ignored; block_in not sampled.
- start in the same cycle as the round-63 handshake ignored (still RUN). Next block may start from IDLE the following cycle.
- Reset values: state IDLE, window all 0, round_idx 0, w_valid 0, busy 0, done 0. k_out = K[0], w_out = 0.
- rst_n low mid-RUN: immediate return to IDLE. No done pulse; partial schedule discarded.

## Timing
- start high at edge N (IDLE) → w_valid=1, round 0 presented after edge N.
- With w_ready tied high, round t is presented in cycle N+1+t. Round 63 is in cycle N+64; done=1 in cycle N+65 with busy=0. A new start is accepted at edge N+65.
- Minimum block period 65 cycles (one idle bubble). Each stall cycle adds one.
- done is a single-cycle pulse, independent of start.
- rst_n deassertion: state changes only on clk edges after release.
- Critical path: σ0/σ1 plus a 4-input 32-bit add, one per cycle.

## Test plan
- Reset:
  - Assert rst_n=0 with random inputs → w_valid=0, busy=0, done=0, round_idx=0, k_out=0x428a2f98.
- "abc" block (block_in = 0x61626380, 14×0, 0x00000018), w_ready=1:
  - Round 0: w_out=0x61626380, k_out=0x428a2f98.
  - Round 15: w_out=0x00000018.
  - Round 16: w_out=0x61626380.
  - Round 17: w_out=0x000F0000.
  - Round 63: k_out=0xc67178f2.
  - done pulses exactly once, 65 cycles after start.
- Stall: drop w_ready for 3 cycles at round 20 → w_out/k_out/round_idx frozen. Resuming gives values identical to the unstalled run; done is delayed by 3 cycles.
- start during RUN at round 10 with a different block_in → ignored; stream matches the first block.
- Back-to-back: start held high continuously →
  - Second block begins exactly one cycle after done.
  - start coincident with the round-63 handshake is not accepted.
- rst_n pulsed low at round 30 → outputs reset immediately, no done. A subsequent start replays round 0 correctly.
